// File: rtl/k005297_pgreg_pkg.sv
// Shared definitions for the K005297 multi-channel page register:
// default geometry, ring tap positions, the per-channel control bundle
// and a width helper for select/counter fields.
package k005297_pgreg_pkg;

  // Default page width and channel count
  localparam int PGREG_PW_DEF = 12;
  localparam int NCH_DEF      = 2;

  // Rotation ring length and tap positions
  localparam int ROTN_DEF     = 20;
  localparam int SH_START_DEF = 12;
  localparam int SH_STOP_DEF  = 0;
  localparam int LD_PHASE_DEF = 19;

  // CPU data bus width
  localparam int DIN_W        = 16;

  // Strobes shared by every channel so all shift registers move in lockstep.
  // ld_sr/shift/inc are already qualified by the 2 MHz enable.
  typedef struct packed {
    logic ld_sr;
    logic shift;
    logic inc;
    logic msbf;
    logic recirc;
  } pgsr_ctrl_t;

  // $clog2 that never returns 0, so a single channel or a 1-bit page
  // still gets a usable 1-bit field.
  function automatic int clog2_min1(input int n);
    int r;
    r = $clog2(n);
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/k005297_pgreg_if.sv
// CPU-side write bus of the page register: a load strobe, the target
// channel and the data word.  The CPU side drives it (master), the page
// register consumes it (slave).
interface k005297_pgreg_if #(
  parameter int NCH = 2
);
  import k005297_pgreg_pkg::*;

  localparam int CSW = clog2_min1(NCH);

  logic             i_PGREG_LD;
  logic [CSW-1:0]   i_CH_SEL;
  logic [DIN_W-1:0] i_DIN;

  modport master (
    output i_PGREG_LD,
    output i_CH_SEL,
    output i_DIN
  );

  modport slave (
    input  i_PGREG_LD,
    input  i_CH_SEL,
    input  i_DIN
  );

endinterface

// File: rtl/k005297_pgsr_ch.sv
// One bubble channel of the page register: the CPU-visible holding
// register and the shift register that serialises it.  All sequencing
// decisions come from the shared control bundle built at the top level.
module k005297_pgsr_ch
  import k005297_pgreg_pkg::*;
#(
  parameter int PW = PGREG_PW_DEF
) (
  input  logic          i_MCLK,
  input  logic          i_SYS_RST_n,
  input  logic          hreg_ld,
  input  logic [PW-1:0] hreg_din,
  input  pgsr_ctrl_t    ctrl,
  output logic [PW-1:0] hreg,
  output logic          sr_bit
);

  logic [PW-1:0] sr;

  // Next shift-register value for one shift.  Written with whole-vector
  // shifts so a 1-bit page degenerates cleanly into a single flop.
  function automatic logic [PW-1:0] shift_next(input logic [PW-1:0] v,
                                               input logic          msbf,
                                               input logic          recirc);
    logic [PW-1:0] r;
    if (msbf) begin
      r        = v << 1;
      r[0]     = recirc & v[PW-1];
    end else begin
      r        = v >> 1;
      r[PW-1]  = recirc & v[0];
    end
    return r;
  endfunction

  // Holding register: a CPU write always beats the window-close increment.
  always_ff @(posedge i_MCLK or negedge i_SYS_RST_n) begin
    if (!i_SYS_RST_n) begin
      hreg <= '0;
    end else if (hreg_ld) begin
      hreg <= hreg_din;
    end else if (ctrl.inc) begin
      hreg <= hreg + PW'(1);
    end
  end

  // Shift register: shifting owns it during the window, so a parallel
  // load requested then is simply lost.
  always_ff @(posedge i_MCLK or negedge i_SYS_RST_n) begin
    if (!i_SYS_RST_n) begin
      sr <= '0;
    end else if (ctrl.shift) begin
      sr <= shift_next(sr, ctrl.msbf, ctrl.recirc);
    end else if (ctrl.ld_sr) begin
      sr <= hreg;
    end
  end

  // Serial tap follows the current shift direction.
  always_comb begin
    sr_bit = ctrl.msbf ? sr[PW-1] : sr[0];
  end

endmodule

// File: rtl/k005297_pgreg_mc.sv
// K005297 multi-channel page register.  Keeps one page address per
// bubble channel and, inside a window of the rotating-phase ring, shifts
// every channel out one bit per 2 MHz enable.  The top level owns the
// window flag, the shift counter / done pulse and the channel decode.
module k005297_pgreg_mc
  import k005297_pgreg_pkg::*;
#(
  parameter int PW       = PGREG_PW_DEF,
  parameter int NCH      = NCH_DEF,
  parameter int ROTN     = ROTN_DEF,
  parameter int SH_START = SH_START_DEF,
  parameter int SH_STOP  = SH_STOP_DEF,
  parameter int LD_PHASE = LD_PHASE_DEF
) (
  input  logic              i_MCLK,
  input  logic              i_SYS_RST_n,
  input  logic              i_CLK2M_PCEN_n,
  input  logic [ROTN-1:0]   i_ROT_n,
  k005297_pgreg_if.slave    bus,
  input  logic              i_PGREG_SR_LD_EN,
  input  logic              i_MODE_MSBF,
  input  logic              i_MODE_RECIRC,
  input  logic              i_AUTO_INC,
  output logic              o_PGREG_SR_SHIFT,
  output logic [NCH-1:0]    o_PGREG_SR_BIT,
  output logic [NCH*PW-1:0] o_PGREG_Q,
  output logic              o_PGREG_SR_DONE
);

  localparam int CSW = clog2_min1(NCH);
  localparam int CW  = clog2_min1(PW + 1);

  logic          ce;
  logic          win_set;
  logic          win_clr;
  logic          set_evt;
  logic          ld_phase;
  logic          win_flag;
  logic [CW-1:0] sh_cnt;
  logic          done_q;
  pgsr_ctrl_t    ctrl;

  // Only the ring taps and the low PW data bits matter; the rest of the
  // ring and the upper CPU data bits are intentionally ignored.
  logic unused_ok;
  assign unused_ok = ^{i_ROT_n, bus.i_DIN};

  // Decode the enable and the three ring taps (ring is one-cold).
  always_comb begin
    ce       = ~i_CLK2M_PCEN_n;
    win_set  = ~i_ROT_n[SH_START];
    win_clr  = ~i_ROT_n[SH_STOP];
    set_evt  = win_set & ~win_clr;
    ld_phase = ~i_ROT_n[LD_PHASE];
  end

  // Shift window flag; closing wins when both taps are low together.
  always_ff @(posedge i_MCLK or negedge i_SYS_RST_n) begin
    if (!i_SYS_RST_n) begin
      win_flag <= 1'b0;
    end else if (ce) begin
      if (win_clr) begin
        win_flag <= 1'b0;
      end else if (win_set) begin
        win_flag <= 1'b1;
      end
    end
  end

  // Shift counter: restarts when the window opens, counts shifts and
  // parks at PW so an over-long window keeps shifting silently.
  always_ff @(posedge i_MCLK or negedge i_SYS_RST_n) begin
    if (!i_SYS_RST_n) begin
      sh_cnt <= '0;
    end else if (ce) begin
      if (set_evt) begin
        sh_cnt <= '0;
      end else if (win_flag && (sh_cnt != CW'(PW))) begin
        sh_cnt <= sh_cnt + CW'(1);
      end
    end
  end

  // Done pulse on the shift that takes the counter from PW-1 to PW.
  always_ff @(posedge i_MCLK or negedge i_SYS_RST_n) begin
    if (!i_SYS_RST_n) begin
      done_q <= 1'b0;
    end else begin
      done_q <= ce & win_flag & ~set_evt & (sh_cnt == CW'(PW - 1));
    end
  end

  // Strobes shared by all channels; modes pass straight through so a
  // change mid-window applies from the next shift on.
  always_comb begin
    ctrl        = '0;
    ctrl.shift  = ce & win_flag;
    ctrl.ld_sr  = ce & ~win_flag & i_PGREG_SR_LD_EN & ld_phase;
    ctrl.inc    = ce & win_flag & win_clr & i_AUTO_INC;
    ctrl.msbf   = i_MODE_MSBF;
    ctrl.recirc = i_MODE_RECIRC;
  end

  // One channel slice per bubble channel; out-of-range selects match none.
  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic hreg_ld;

    assign hreg_ld = bus.i_PGREG_LD && (bus.i_CH_SEL == CSW'(k));

    k005297_pgsr_ch #(
      .PW (PW)
    ) u_ch (
      .i_MCLK      (i_MCLK),
      .i_SYS_RST_n (i_SYS_RST_n),
      .hreg_ld     (hreg_ld),
      .hreg_din    (bus.i_DIN[PW-1:0]),
      .ctrl        (ctrl),
      .hreg        (o_PGREG_Q[k*PW +: PW]),
      .sr_bit      (o_PGREG_SR_BIT[k])
    );
  end

  assign o_PGREG_SR_SHIFT = win_flag;
  assign o_PGREG_SR_DONE  = done_q;

endmodule

// File: tb/tb_k005297_pgreg_mc.sv
// Bench for k005297_pgreg_mc: a 12-bit/2-channel and an 8-bit/4-channel
// instance run side by side from the same ring and CPU stimulus.
// Expected serial bits are queued when a window is loaded and popped
// before each shift.
module tb_k005297_pgreg_mc;
  import k005297_pgreg_pkg::*;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, pcen_n, ld_en, msbf, rc, ainc, ld;
  logic [19:0] rot;
  logic [1:0]  ch_sel;
  logic [15:0] din;

  logic        sh_a, done_a, sh_b, done_b;
  logic [1:0]  bit_a;
  logic [3:0]  bit_b;
  logic [23:0] q_a;
  logic [31:0] q_b;

  logic [11:0] ha[2];
  logic [7:0]  hb[4];
  logic [5:0]  sb_q[$];
  int          total = 0;
  int          bad   = 0;

  k005297_pgreg_if #(.NCH(2)) bus_a();
  k005297_pgreg_if #(.NCH(4)) bus_b();

  assign bus_a.i_PGREG_LD = ld;
  assign bus_a.i_CH_SEL   = ch_sel[0];
  assign bus_a.i_DIN      = din;
  assign bus_b.i_PGREG_LD = ld;
  assign bus_b.i_CH_SEL   = ch_sel;
  assign bus_b.i_DIN      = din;

  k005297_pgreg_mc #(.PW(12), .NCH(2)) dut_a (
    .i_MCLK(clk), .i_SYS_RST_n(rst_n), .i_CLK2M_PCEN_n(pcen_n), .i_ROT_n(rot),
    .bus(bus_a), .i_PGREG_SR_LD_EN(ld_en), .i_MODE_MSBF(msbf),
    .i_MODE_RECIRC(rc), .i_AUTO_INC(ainc), .o_PGREG_SR_SHIFT(sh_a),
    .o_PGREG_SR_BIT(bit_a), .o_PGREG_Q(q_a), .o_PGREG_SR_DONE(done_a)
  );

  k005297_pgreg_mc #(.PW(8), .NCH(4)) dut_b (
    .i_MCLK(clk), .i_SYS_RST_n(rst_n), .i_CLK2M_PCEN_n(pcen_n), .i_ROT_n(rot),
    .bus(bus_b), .i_PGREG_SR_LD_EN(ld_en), .i_MODE_MSBF(msbf),
    .i_MODE_RECIRC(rc), .i_AUTO_INC(ainc), .o_PGREG_SR_SHIFT(sh_b),
    .o_PGREG_SR_BIT(bit_b), .o_PGREG_Q(q_b), .o_PGREG_SR_DONE(done_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [19:0] ring(input int p);
    logic [19:0] r;
    r    = '1;
    r[p] = 1'b0;
    return r;
  endfunction

  // Bit presented before shift i of a register loaded with v.
  function automatic logic eb(input logic [15:0] v, input int pw, input int i,
                              input logic m, input logic re);
    int j;
    if (!re && i >= pw) return 1'b0;
    j = i % pw;
    return m ? v[pw-1-j] : v[j];
  endfunction

  function automatic logic [5:0] exp_vec(input int i);
    return {eb(16'(hb[3]), 8, i, msbf, rc), eb(16'(hb[2]), 8, i, msbf, rc),
            eb(16'(hb[1]), 8, i, msbf, rc), eb(16'(hb[0]), 8, i, msbf, rc),
            eb(16'(ha[1]), 12, i, msbf, rc), eb(16'(ha[0]), 12, i, msbf, rc)};
  endfunction

  task automatic push_win(input int n);
    for (int i = 0; i < n; i++) sb_q.push_back(exp_vec(i));
  endtask

  task automatic chk_bits();
    logic [5:0] e;
    chk("sb_len", 64'(sb_q.size() != 0), 64'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk("bits", {bit_b, bit_a}, e);
    end
  endtask

  task automatic wr(input int ch, input logic [15:0] val);
    ld = 1'b1; ch_sel = 2'(ch); din = val;
    step();
    ld = 1'b0;
    if (ch < 2) ha[ch] = val[11:0];
    hb[ch] = val[7:0];
  endtask

  task automatic chk_q();
    chk("q_a", q_a, {ha[1], ha[0]});
    chk("q_b", q_b, {hb[3], hb[2], hb[1], hb[0]});
  endtask

  // One enabled MCLK with ring value r, then one idle MCLK.
  task automatic ce_tick(input logic [19:0] r, input logic eda, input logic edb);
    rot = r; pcen_n = 1'b0;
    step();
    chk("done_a", done_a, eda);
    chk("done_b", done_b, edb);
    pcen_n = 1'b1; ld = 1'b0;
    step();
    chk("done_w", {done_b, done_a}, 2'b00);
  endtask

  // Full descending ring pass from phase 19 down to last_p.
  task automatic run_ring(input int last_p, input bit collide);
    for (int p = 19; p >= last_p; p--) begin
      if (p <= 11) chk_bits();
      if (p == 19) push_win(12);
      if (collide && p == 0) begin
        ld = 1'b1; ch_sel = 2'd1; din = 16'h0123;
      end
      ce_tick(ring(p), p == 0, p == 4);
      chk("shift_a", sh_a, (p >= 1 && p <= 12));
      chk("shift_b", sh_b, (p >= 1 && p <= 12));
    end
  endtask

  initial begin
    rst_n = 1'b0; pcen_n = 1'b1; rot = '1; ld_en = 1'b0; msbf = 1'b0;
    rc = 1'b0; ainc = 1'b0; ld = 1'b0; ch_sel = '0; din = '0;
    for (int k = 0; k < 2; k++) ha[k] = '0;
    for (int k = 0; k < 4; k++) hb[k] = '0;

    // Reset held with random inputs
    repeat (4) begin
      pcen_n = 1'($urandom); rot = 20'($urandom); ld = 1'($urandom);
      ch_sel = 2'($urandom); din = 16'($urandom); ld_en = 1'($urandom);
      msbf = 1'($urandom); rc = 1'($urandom); ainc = 1'($urandom);
      step();
      chk("rst_out", {sh_a, done_a, bit_a, sh_b, done_b, bit_b}, 0);
      chk("rst_q", {q_b, q_a}, 0);
    end
    pcen_n = 1'b1; rot = '1; ld = 1'b0; ch_sel = '0; din = '0;
    ld_en = 1'b0; msbf = 1'b0; rc = 1'b0; ainc = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk_q();

    // Load and shift, LSB first, zero fill
    wr(0, 16'hFA5C);
    wr(1, 16'h03F1);
    chk_q();
    ld_en = 1'b1;
    run_ring(0, 1'b0);
    chk("t2_sr_lsb", {bit_b, bit_a}, 6'b0);
    msbf = 1'b1; #1;
    chk("t2_sr_msb", {bit_b, bit_a}, 6'b0);
    msbf = 1'b0;

    // MSB first with recirculation
    wr(0, 16'h0801);
    msbf = 1'b1; rc = 1'b1;
    run_ring(0, 1'b0);
    chk("t3_sr_msb", {bit_b, bit_a}, exp_vec(12));
    msbf = 1'b0; #1;
    chk("t3_sr_lsb", {bit_b, bit_a}, 6'b0010_11);
    rc = 1'b0;

    // Auto-increment with a colliding CPU write on channel 1
    wr(0, 16'h0FFF);
    wr(1, 16'h0456);
    ainc = 1'b1;
    run_ring(0, 1'b1);
    for (int k = 0; k < 2; k++) ha[k] = ha[k] + 12'd1;
    for (int k = 0; k < 4; k++) hb[k] = hb[k] + 8'd1;
    ha[1] = 12'h123; hb[1] = 8'h23;
    ainc = 1'b0;
    chk_q();

    // Load request inside the window, then set+clear together
    msbf = 1'b0; rc = 1'b1;
    wr(0, 16'h000F);
    push_win(4);
    ce_tick(ring(19), 1'b0, 1'b0);
    for (int p = 18; p >= 12; p--) ce_tick(ring(p), 1'b0, 1'b0);
    chk("t5_open", {sh_b, sh_a}, 2'b11);
    chk_bits(); ce_tick(ring(11), 1'b0, 1'b0);
    chk_bits(); ce_tick(ring(10), 1'b0, 1'b0);
    wr(0, 16'h0ABC);
    chk_bits(); ce_tick(ring(19), 1'b0, 1'b0);
    chk("t5_win", {sh_b, sh_a}, 2'b11);
    chk_bits(); ce_tick(ring(12) & ring(0), 1'b0, 1'b0);
    chk("t5_clr", {sh_b, sh_a}, 2'b00);
    msbf = 1'b1; #1;
    chk("t5_sr", {bit_b, bit_a}, 6'b0001_01);
    msbf = 1'b0;
    chk_q();

    // Reset in the middle of a window
    rc = 1'b0;
    run_ring(7, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("t6_out", {sh_a, done_a, bit_a, sh_b, done_b, bit_b}, 0);
    chk("t6_q", {q_b, q_a}, 0);
    sb_q.delete();
    for (int k = 0; k < 2; k++) ha[k] = '0;
    for (int k = 0; k < 4; k++) hb[k] = '0;
    repeat (2) begin
      pcen_n = 1'b0;
      step();
      chk("t6_done", {done_b, done_a, sh_b, sh_a}, 0);
    end
    pcen_n = 1'b1;
    rst_n = 1'b1;
    step();
    chk_q();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
